mem_stage: RTL and testbench

//  MEM pipeline stage between EX and WB. Registers one EX payload, waits for the data-SRAM

---
 rtl/mem_stage.sv | 159 +++++++++++++++
 tb/tb_mem_stage.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/mem_stage.sv
// MEM pipeline stage: holds one EX payload, collects its data-SRAM response, offers it to WB.
// Non-memory ops reach WB one cycle after capture; loads/stores wait for data_ok; held while !wb_ready.
module mem_stage #(
  parameter int DROP_W = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        flush,
  input  logic        ex_valid,
  output logic        ex_ready,
  input  logic [31:0] ex_pc,
  input  logic [31:0] ex_result,
  input  logic [7:0]  ex_mem_op,
  input  logic        ex_res_from_mem,
  input  logic        ex_gr_we,
  input  logic [4:0]  ex_dest,
  input  logic        ex_req_sent,
  input  logic        ex_exc,
  input  logic [5:0]  ex_ecode,
  input  logic [8:0]  ex_esubcode,
  input  logic [31:0] ex_maddr,
  input  logic        ex_ertn,
  input  logic        ex_rdcntid,
  input  logic        data_sram_data_ok,
  input  logic [31:0] data_sram_rdata,
  output logic        wb_valid,
  input  logic        wb_ready,
  output logic [31:0] wb_pc,
  output logic [31:0] wb_result,
  output logic [7:0]  wb_mem_op,
  output logic        wb_res_from_mem,
  output logic        wb_gr_we,
  output logic [4:0]  wb_dest,
  output logic        wb_req_sent,
  output logic        wb_exc,
  output logic [5:0]  wb_ecode,
  output logic [8:0]  wb_esubcode,
  output logic [31:0] wb_maddr,
  output logic        wb_ertn,
  output logic        wb_rdcntid,
  output logic [31:0] wb_rdata,
  output logic        fwd_we,
  output logic [4:0]  fwd_dest,
  output logic [31:0] fwd_data,
  output logic        fwd_stall
);

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] result;
    logic [7:0]  mem_op;
    logic        res_from_mem;
    logic        gr_we;
    logic [4:0]  dest;
    logic        req_sent;
    logic        exc;
    logic [5:0]  ecode;
    logic [8:0]  esubcode;
    logic [31:0] maddr;
    logic        ertn;
    logic        rdcntid;
  } pl_t;

  typedef enum logic [1:0] {S_EMPTY, S_WAIT, S_DONE} state_e;

  localparam logic [DROP_W-1:0] DROP_MAX = '1;

  state_e            state_q, state_d;
  pl_t               pl_q, pl_d, ex_pl;
  logic [31:0]       rdata_q, rdata_d;
  logic [DROP_W-1:0] drop_q, drop_d;
  logic [DROP_W:0]   drop_sum;
  logic              capture, resp_take, resp_drop, inc_wait, inc_cap;

  assign ex_pl = '{pc: ex_pc, result: ex_result, mem_op: ex_mem_op,
                   res_from_mem: ex_res_from_mem, gr_we: ex_gr_we, dest: ex_dest,
                   req_sent: ex_req_sent, exc: ex_exc, ecode: ex_ecode,
                   esubcode: ex_esubcode, maddr: ex_maddr, ertn: ex_ertn,
                   rdcntid: ex_rdcntid};

  assign ex_ready  = ((state_q == S_EMPTY) | ((state_q == S_DONE) & wb_ready))
                   & (drop_q != DROP_MAX);
  assign wb_valid  = (state_q == S_DONE) & ~flush;
  assign capture   = ex_valid & ex_ready & ~flush;
  assign resp_drop = data_sram_data_ok & (drop_q != '0);
  assign resp_take = data_sram_data_ok & (drop_q == '0) & (state_q == S_WAIT);

  // A response arriving in the very cycle of the flush is consumed, so nothing extra is owed.
  assign inc_wait = flush & (state_q == S_WAIT) & ~resp_take;
  assign inc_cap  = flush & ex_valid & ex_ready & ex_req_sent;

  always_comb begin
    drop_sum = {1'b0, drop_q} + (DROP_W+1)'(inc_wait) + (DROP_W+1)'(inc_cap)
             - (DROP_W+1)'(resp_drop);
    if (drop_sum > {1'b0, DROP_MAX}) drop_d = DROP_MAX;
    else                             drop_d = drop_sum[DROP_W-1:0];
  end

  always_comb begin
    state_d = state_q;
    pl_d    = pl_q;
    rdata_d = rdata_q;
    if (flush) begin
      state_d = S_EMPTY;
      pl_d    = '0;
      rdata_d = '0;
    end else if (capture) begin
      pl_d    = ex_pl;
      rdata_d = '0;
      state_d = (ex_req_sent & ~ex_exc) ? S_WAIT : S_DONE;
    end else begin
      case (state_q)
        S_WAIT: if (resp_take) begin
          state_d = S_DONE;
          if (pl_q.res_from_mem) rdata_d = data_sram_rdata;
        end
        S_DONE:  if (wb_ready) state_d = S_EMPTY;
        S_EMPTY: state_d = S_EMPTY;
        default: state_d = S_EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_EMPTY;
      pl_q    <= '0;
      rdata_q <= '0;
      drop_q  <= '0;
    end else begin
      state_q <= state_d;
      pl_q    <= pl_d;
      rdata_q <= rdata_d;
      drop_q  <= drop_d;
    end
  end

  assign wb_pc           = pl_q.pc;
  assign wb_result       = pl_q.result;
  assign wb_mem_op       = pl_q.mem_op;
  assign wb_res_from_mem = pl_q.res_from_mem;
  assign wb_gr_we        = pl_q.gr_we;
  assign wb_dest         = pl_q.dest;
  assign wb_req_sent     = pl_q.req_sent;
  assign wb_exc          = pl_q.exc;
  assign wb_ecode        = pl_q.ecode;
  assign wb_esubcode     = pl_q.esubcode;
  assign wb_maddr        = pl_q.maddr;
  assign wb_ertn         = pl_q.ertn;
  assign wb_rdcntid      = pl_q.rdcntid;
  assign wb_rdata        = rdata_q;

  // Load data only becomes forwardable once the response has landed.
  assign fwd_we    = (state_q != S_EMPTY) & pl_q.gr_we & ~pl_q.exc & (pl_q.dest != 5'd0);
  assign fwd_dest  = pl_q.dest;
  assign fwd_data  = (pl_q.res_from_mem & (state_q == S_DONE)) ? rdata_q : pl_q.result;
  assign fwd_stall = fwd_we & pl_q.res_from_mem & (state_q == S_WAIT);

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage: ALU pass-through, load wait, backpressure, flush drop, exception, async reset.
module tb_mem_stage;
  logic        clk = 1'b0;
  logic        rst, flush, ex_valid, ex_ready;
  logic [31:0] ex_pc, ex_result, ex_maddr;
  logic [7:0]  ex_mem_op;
  logic        ex_res_from_mem, ex_gr_we, ex_req_sent, ex_exc, ex_ertn, ex_rdcntid;
  logic [4:0]  ex_dest;
  logic [5:0]  ex_ecode;
  logic [8:0]  ex_esubcode;
  logic        data_sram_data_ok;
  logic [31:0] data_sram_rdata;
  logic        wb_valid, wb_ready;
  logic [31:0] wb_pc, wb_result, wb_maddr, wb_rdata;
  logic [7:0]  wb_mem_op;
  logic        wb_res_from_mem, wb_gr_we, wb_req_sent, wb_exc, wb_ertn, wb_rdcntid;
  logic [4:0]  wb_dest;
  logic [5:0]  wb_ecode;
  logic [8:0]  wb_esubcode;
  logic        fwd_we, fwd_stall;
  logic [4:0]  fwd_dest;
  logic [31:0] fwd_data;

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  mem_stage #(.DROP_W(2)) dut (
    .clk(clk), .rst(rst), .flush(flush), .ex_valid(ex_valid), .ex_ready(ex_ready),
    .ex_pc(ex_pc), .ex_result(ex_result), .ex_mem_op(ex_mem_op),
    .ex_res_from_mem(ex_res_from_mem), .ex_gr_we(ex_gr_we), .ex_dest(ex_dest),
    .ex_req_sent(ex_req_sent), .ex_exc(ex_exc), .ex_ecode(ex_ecode),
    .ex_esubcode(ex_esubcode), .ex_maddr(ex_maddr), .ex_ertn(ex_ertn),
    .ex_rdcntid(ex_rdcntid), .data_sram_data_ok(data_sram_data_ok),
    .data_sram_rdata(data_sram_rdata), .wb_valid(wb_valid), .wb_ready(wb_ready),
    .wb_pc(wb_pc), .wb_result(wb_result), .wb_mem_op(wb_mem_op),
    .wb_res_from_mem(wb_res_from_mem), .wb_gr_we(wb_gr_we), .wb_dest(wb_dest),
    .wb_req_sent(wb_req_sent), .wb_exc(wb_exc), .wb_ecode(wb_ecode),
    .wb_esubcode(wb_esubcode), .wb_maddr(wb_maddr), .wb_ertn(wb_ertn),
    .wb_rdcntid(wb_rdcntid), .wb_rdata(wb_rdata), .fwd_we(fwd_we),
    .fwd_dest(fwd_dest), .fwd_data(fwd_data), .fwd_stall(fwd_stall)
  );

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    flush = 0; ex_valid = 0; ex_pc = 0; ex_result = 0; ex_mem_op = 0;
    ex_res_from_mem = 0; ex_gr_we = 0; ex_dest = 0; ex_req_sent = 0; ex_exc = 0;
    ex_ecode = 0; ex_esubcode = 0; ex_maddr = 0; ex_ertn = 0; ex_rdcntid = 0;
    data_sram_data_ok = 0; data_sram_rdata = 0; wb_ready = 1;
  endtask

  task automatic drive_load(input logic [31:0] pc, input logic [7:0] op, input logic [4:0] dst);
    ex_valid = 1; ex_pc = pc; ex_result = 32'h100; ex_mem_op = op;
    ex_res_from_mem = 1; ex_gr_we = 1; ex_dest = dst; ex_req_sent = 1;
  endtask

  initial begin
    idle();
    rst = 1;
    #12;
    chk("rst_wb_valid", wb_valid, 0);
    chk("rst_wb_pc", wb_pc, 0);
    chk("rst_wb_rdata", wb_rdata, 0);
    rst = 0;
    tick();
    chk("rst_ex_ready", ex_ready, 1);

    // ALU op
    ex_valid = 1; ex_pc = 32'h1c000000; ex_result = 32'h5; ex_gr_we = 1; ex_dest = 5'd3;
    #1 chk("alu_ex_ready", ex_ready, 1);
    tick(); idle(); #1;
    chk("alu_wb_valid", wb_valid, 1);
    chk("alu_wb_pc", wb_pc, 32'h1c000000);
    chk("alu_wb_result", wb_result, 32'h5);
    chk("alu_fwd_we", fwd_we, 1);
    chk("alu_fwd_data", fwd_data, 32'h5);
    tick();
    chk("alu_drain_valid", wb_valid, 0);
    chk("alu_drain_ready", ex_ready, 1);

    // LW with response three cycles after capture
    drive_load(32'h1c000004, 8'b0000_0100, 5'd4);
    tick(); idle(); #1;
    chk("lw_stall1", fwd_stall, 1);
    chk("lw_valid1", wb_valid, 0);
    tick();
    chk("lw_stall2", fwd_stall, 1);
    tick();
    chk("lw_stall3", fwd_stall, 1);
    data_sram_data_ok = 1; data_sram_rdata = 32'hdeadbeef;
    tick(); idle(); #1;
    chk("lw_wb_valid", wb_valid, 1);
    chk("lw_wb_rdata", wb_rdata, 32'hdeadbeef);
    chk("lw_fwd_data", fwd_data, 32'hdeadbeef);
    chk("lw_stall_off", fwd_stall, 0);
    tick();

    // WB backpressure then back-to-back capture
    wb_ready = 0; ex_valid = 1; ex_pc = 32'h10; ex_result = 32'h11; ex_gr_we = 1; ex_dest = 5'd7;
    tick();
    ex_pc = 32'h20; ex_result = 32'h22; #1;
    chk("bp_ex_ready", ex_ready, 0);
    chk("bp_wb_valid", wb_valid, 1);
    tick();
    chk("bp_hold_pc", wb_pc, 32'h10);
    chk("bp_hold_result", wb_result, 32'h11);
    wb_ready = 1; #1;
    chk("bp_release_ready", ex_ready, 1);
    tick(); idle(); #1;
    chk("b2b_wb_pc", wb_pc, 32'h20);
    chk("b2b_wb_valid", wb_valid, 1);
    tick();

    // flush during WAIT; stale response arrives alongside the next capture
    drive_load(32'h30, 8'b0000_0100, 5'd4);
    tick(); idle();
    flush = 1; #1;
    chk("fl_wb_valid", wb_valid, 0);
    tick(); idle(); #1;
    chk("fl_drop_cnt", dut.drop_q, 1);
    chk("fl_cleared", wb_result, 0);
    drive_load(32'h40, 8'b0000_0001, 5'd5);
    ex_result = 32'h203;
    data_sram_data_ok = 1; data_sram_rdata = 32'h1234;
    tick(); idle(); #1;
    chk("fl_drop_done", dut.drop_q, 0);
    chk("fl_new_stall", fwd_stall, 1);
    data_sram_data_ok = 1; data_sram_rdata = 32'h80;
    tick(); idle(); #1;
    chk("fl_new_valid", wb_valid, 1);
    chk("fl_new_rdata", wb_rdata, 32'h80);
    tick();

    // upstream exception bypasses WAIT
    drive_load(32'h50, 8'b0000_0100, 5'd6);
    ex_req_sent = 0; ex_exc = 1; ex_ecode = 6'h9; ex_maddr = 32'h3; ex_esubcode = 9'h1;
    tick(); idle(); #1;
    chk("exc_wb_valid", wb_valid, 1);
    chk("exc_ecode", wb_ecode, 6'h9);
    chk("exc_maddr", wb_maddr, 32'h3);
    chk("exc_esub", wb_esubcode, 9'h1);
    chk("exc_fwd_we", fwd_we, 0);
    tick();

    // async reset mid-WAIT with a response still owed
    drive_load(32'h60, 8'b0000_0100, 5'd4);
    tick(); idle(); flush = 1;
    tick(); idle();
    drive_load(32'h64, 8'b0000_0100, 5'd4);
    tick(); idle(); #1;
    chk("rw_pre_stall", fwd_stall, 1);
    chk("rw_pre_drop", dut.drop_q, 1);
    rst = 1; #1;
    chk("rw_wb_valid", wb_valid, 0);
    chk("rw_ex_ready", ex_ready, 1);
    chk("rw_drop", dut.drop_q, 0);
    chk("rw_stall", fwd_stall, 0);
    chk("rw_pc", wb_pc, 0);
    tick(); rst = 0;
    tick();

    // drop counter saturation and ex_ready gating
    flush = 1; drive_load(32'h70, 8'b0000_0100, 5'd4);
    tick(); tick(); tick(); #1;
    chk("sat_drop3", dut.drop_q, 3);
    chk("sat_ready0", ex_ready, 0);
    tick();
    chk("sat_hold", dut.drop_q, 3);
    idle(); data_sram_data_ok = 1;
    tick(); idle(); #1;
    chk("sat_dec", dut.drop_q, 2);
    chk("sat_ready1", ex_ready, 1);
    data_sram_data_ok = 1;
    tick(); tick(); idle(); #1;
    chk("sat_drain", dut.drop_q, 0);
    chk("sat_empty_valid", wb_valid, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end
endmodule
